// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and widths for the LFSR run controller and its cycle counter.
package lfsr_ctrl_pkg;

    localparam int LFSR_W             = 22;
    localparam int MATCH_W            = 13;
    localparam int CYC_W              = 23;
    localparam int MAX_CYCLES_DEFAULT = 4194304;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/lfsr_period_counter.sv
// Saturating loop-length counter: clears to zero, counts up while enabled, holds at MAX_CYCLES.
module lfsr_period_counter
    import lfsr_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count,
    output logic             at_max
);

    localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);

    assign at_max = (count == MAX_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_run_controller.sv
// Sequences one LFSR loop-length measurement run and captures the detector match count.
// Optional macro PERIOD_CHECK_EN adds the period_ok output and its reference compare.
module lfsr_run_controller
    import lfsr_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
`ifdef PERIOD_CHECK_EN
    ,
    parameter int EXPECTED_PERIOD = 4194303
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [LFSR_W-1:0]  seed,
    input  logic [LFSR_W-1:0]  lfsr_state,
    input  logic [MATCH_W-1:0] match_count,
    output logic               lfsr_load,
    output logic [LFSR_W-1:0]  lfsr_seed,
    output logic               lfsr_en,
    output logic               det_reset,
    output logic               busy,
    output logic               done,
    output logic [CYC_W-1:0]   period_len,
    output logic [MATCH_W-1:0] result_matches,
    output logic               timeout,
    output logic               seed_err,
`ifdef PERIOD_CHECK_EN
    output logic               period_ok,
`endif
    output logic               aborted
);

    // state | meaning
    // IDLE  | waiting for start, results held
    // LOAD  | seed strobed into LFSR, detector cleared
    // RUN   | LFSR stepping, counting until loop, limit or abort
    // DRAIN | LFSR stopped, detector's registered count settles
    // DONE  | done pulse, then back to IDLE

    state_t           state, state_nxt;
    logic [CYC_W-1:0] cnt;
    logic             cnt_at_max;
    logic             start_acc;
    logic             loop_hit;

    assign start_acc = (state == IDLE) && start;
    assign loop_hit  = (lfsr_state == lfsr_seed) && (cnt != '0);

    lfsr_period_counter #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state == IDLE) || (state == LOAD)),
        .enable (state == RUN),
        .count  (cnt),
        .at_max (cnt_at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        det_reset = 1'b0;
        lfsr_en   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (seed == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                lfsr_load = 1'b1;
                det_reset = 1'b1;
                state_nxt = abort ? DRAIN : RUN;
            end
            RUN: begin
                lfsr_en = 1'b1;
                if (abort || loop_hit || cnt_at_max) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Result registers are cleared on an accepted start so a seed error run reports zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_seed      <= '0;
            period_len     <= '0;
            result_matches <= '0;
            timeout        <= 1'b0;
            seed_err       <= 1'b0;
            aborted        <= 1'b0;
`ifdef PERIOD_CHECK_EN
            period_ok      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        lfsr_seed      <= seed;
                        period_len     <= '0;
                        result_matches <= '0;
                        timeout        <= 1'b0;
                        seed_err       <= (seed == '0);
                        aborted        <= 1'b0;
`ifdef PERIOD_CHECK_EN
                        period_ok      <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        aborted    <= 1'b1;
                        period_len <= cnt;
                    end
                end
                RUN: begin
                    // Abort outranks loop detection, which outranks the cycle limit.
                    if (abort) begin
                        aborted    <= 1'b1;
                        period_len <= cnt;
                    end else if (loop_hit) begin
                        period_len <= cnt;
                    end else if (cnt_at_max) begin
                        timeout    <= 1'b1;
                        period_len <= cnt;
                    end
                end
                DRAIN: begin
                    result_matches <= match_count;
                end
                DONE: begin
`ifdef PERIOD_CHECK_EN
                    period_ok <= (period_len == CYC_W'(EXPECTED_PERIOD)) &&
                                 !timeout && !aborted && !seed_err;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_run_controller.sv
// Randomized self-checking bench for lfsr_run_controller with a stub LFSR environment.
module tb_lfsr_run_controller;
    import lfsr_ctrl_pkg::*;

    localparam int MAXC = 100;
    localparam int EXPP = 7;

    logic               clk = 1'b0;
    logic               reset, start, abort;
    logic [LFSR_W-1:0]  seed, lfsr_state;
    logic [MATCH_W-1:0] match_count;
    logic               lfsr_load, lfsr_en, det_reset, busy, done;
    logic               timeout, seed_err, aborted;
    logic [LFSR_W-1:0]  lfsr_seed;
    logic [CYC_W-1:0]   period_len;
    logic [MATCH_W-1:0] result_matches;
`ifdef PERIOD_CHECK_EN
    logic               period_ok;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the values held from the previous run.
    logic [LFSR_W-1:0]  p_seed;
    int                 p_plen, p_matches;
    bit                 p_to, p_se, p_ab, p_ok;

    // Stub LFSR: stub_len == 0 steps a maximal 22-bit LFSR, otherwise loops every stub_len steps.
    int                 stub_len = 0;
    int                 stub_k;
    logic [LFSR_W-1:0]  stub_base;

    always #5 clk = ~clk;

    lfsr_run_controller #(
        .MAX_CYCLES (MAXC)
`ifdef PERIOD_CHECK_EN
        , .EXPECTED_PERIOD (EXPP)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .seed           (seed),
        .lfsr_state     (lfsr_state),
        .match_count    (match_count),
        .lfsr_load      (lfsr_load),
        .lfsr_seed      (lfsr_seed),
        .lfsr_en        (lfsr_en),
        .det_reset      (det_reset),
        .busy           (busy),
        .done           (done),
        .period_len     (period_len),
        .result_matches (result_matches),
        .timeout        (timeout),
        .seed_err       (seed_err),
`ifdef PERIOD_CHECK_EN
        .period_ok      (period_ok),
`endif
        .aborted        (aborted)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_state <= '0;
            stub_base  <= '0;
            stub_k     <= 0;
        end else if (lfsr_load) begin
            lfsr_state <= lfsr_seed;
            stub_base  <= lfsr_seed;
            stub_k     <= 0;
        end else if (lfsr_en) begin
            if (stub_len == 0) begin
                lfsr_state <= {lfsr_state[LFSR_W-2:0], lfsr_state[21] ^ lfsr_state[20]};
            end else begin
                stub_k     <= (stub_k + 1) % stub_len;
                lfsr_state <= stub_base ^ LFSR_W'((stub_k + 1) % stub_len);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        p_seed = '0; p_plen = 0; p_matches = 0;
        p_to = 0; p_se = 0; p_ab = 0; p_ok = 0;
    endtask

    // One run: len 0 never returns; abort_at -2 none, -1 in LOAD, n on RUN cycle n; mc_fixed -1 random.
    task automatic run_case(input logic [LFSR_W-1:0] s, input int len, input int abort_at,
                            input bit noise, input int mc_fixed);
        int  r, endi, plen, drain_c, done_c, total, cap;
        bit  se, to, ab, ok, in_run, in_load, in_done;
        se = (s == '0);
        to = 0; ab = 0; plen = 0; r = 0; cap = 0;
        stub_len = len;
        if (se) begin
            r = 0;
        end else if (abort_at == -1) begin
            ab = 1;
        end else begin
            endi = MAXC; to = 1;
            if (len > 0 && len <= endi) begin endi = len; to = 0; end
            if (abort_at >= 0 && abort_at <= endi) begin endi = abort_at; ab = 1; to = 0; end
            plen = endi;
            r = endi + 1;
        end
        drain_c = 2 + r;
        done_c  = se ? 1 : 3 + r;
        total   = done_c + 2;
        ok      = !se && !to && !ab && (plen == EXPP);
        for (int c = 0; c < total; c++) begin
            @(posedge clk); #1;
            seed  = (c == 0) ? s : LFSR_W'($urandom);
            start = (c == 0) || (noise && c >= 1 && c <= done_c && $urandom_range(0, 3) == 0);
            abort = (!se && abort_at == -1 && c == 1) || (!se && abort_at >= 0 && c == 2 + abort_at) ||
                    (noise && (c == 0 || c >= drain_c) && $urandom_range(0, 2) == 0);
            match_count = (mc_fixed >= 0) ? MATCH_W'(mc_fixed) : MATCH_W'($urandom);
            @(negedge clk);
            if (!se && c == drain_c) cap = match_count;
            in_load = !se && c == 1;
            in_run  = !se && c >= 2 && c < drain_c;
            in_done = c == done_c;
            chk("busy", busy, (c >= 1 && c <= done_c));
            chk("done", done, in_done);
            chk("lfsr_load", lfsr_load, in_load);
            chk("det_reset", det_reset, in_load);
            chk("lfsr_en", lfsr_en, in_run);
            chk("lfsr_seed", lfsr_seed, (c == 0) ? p_seed : s);
            if (c == 0) begin
                chk("period_len", period_len, p_plen);
                chk("result_matches", result_matches, p_matches);
                chk("timeout", timeout, p_to);
                chk("seed_err", seed_err, p_se);
                chk("aborted", aborted, p_ab);
            end else begin
                chk("period_len", period_len, (se || c >= drain_c) ? plen : 0);
                chk("result_matches", result_matches, (!se && c >= done_c) ? cap : 0);
                chk("timeout", timeout, (c >= drain_c) ? to : 0);
                chk("seed_err", seed_err, se);
                chk("aborted", aborted, (c >= drain_c) ? ab : 0);
            end
`ifdef PERIOD_CHECK_EN
            chk("period_ok", period_ok, (c == 0) ? p_ok : ((c > done_c) ? ok : 0));
`endif
        end
        start = 0; abort = 0;
        p_seed = s; p_plen = plen; p_matches = se ? 0 : cap;
        p_to = to; p_se = se; p_ab = ab; p_ok = ok;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; match_count = '0;
        clear_model();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load", lfsr_load, 0);
        chk("rst_period_len", period_len, 0);
        chk("rst_lfsr_seed", lfsr_seed, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed runs with literal expectations.
        run_case(22'h000001, 0, -2, 0, -1);
        chk("lit_timeout_len", period_len, 100);
        chk("lit_timeout_flag", timeout, 1);
        run_case(22'h0002AB, 0, 50, 0, 13'h0A5);
        chk("lit_abort_len", period_len, 50);
        chk("lit_abort_matches", result_matches, 13'h0A5);
        chk("lit_abort_flag", aborted, 1);
        run_case(22'h000000, 5, -2, 0, -1);
        chk("lit_seed_err", seed_err, 1);
        run_case(22'h3C0F11, 7, -2, 0, -1);
        chk("lit_loop7_len", period_len, 7);
`ifdef PERIOD_CHECK_EN
        chk("lit_period_ok7", period_ok, 1);
`endif
        run_case(22'h0ABCDE, 8, -2, 0, -1);
        chk("lit_loop8_len", period_len, 8);
`ifdef PERIOD_CHECK_EN
        chk("lit_period_ok8", period_ok, 0);
`endif
        run_case(22'h123456, 100, -2, 0, -1);
        chk("lit_tie_len", period_len, 100);
        chk("lit_tie_timeout", timeout, 0);
        run_case(22'h2468AC, 12, -1, 0, -1);
        chk("lit_load_abort_len", period_len, 0);
        run_case(22'h111111, 9, 9, 0, -1);
        chk("lit_abort_vs_loop", aborted, 1);

        for (int i = 0; i < 40; i++) begin
            logic [LFSR_W-1:0] s;
            int len, ab;
            s   = ($urandom_range(0, 9) == 0) ? '0 : LFSR_W'($urandom);
            len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 120));
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 110)) - 1 : -2;
            run_case(s, len, ab, 1, -1);
        end

        // Reset mid-run: re-pulsed start ignored, outputs zero asynchronously, no done.
        stub_len = 0;
        @(posedge clk); #1;
        seed = 22'h155AA; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start = (c == 5);
            seed  = 22'h2F00F;
            @(negedge clk);
            chk("mid_busy", busy, 1);
            chk("mid_done", done, 0);
            chk("mid_seed_hold", lfsr_seed, 22'h155AA);
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_en", lfsr_en, 0);
        chk("arst_seed", lfsr_seed, 0);
        chk("arst_len", period_len, 0);
        chk("arst_matches", result_matches, 0);
        chk("arst_flags", {timeout, seed_err, aborted}, 0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        clear_model();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_done", done, 0);
        end
        run_case(22'h000005, 3, -2, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
